// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus-mapped timer: register offsets, TCON bit positions, counter states.
package bus_timer_pkg;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN      = 0;
    localparam int TCON_IE      = 1;
    localparam int TCON_IF      = 2;
    localparam int TCON_ONESHOT = 3;

    typedef enum logic [1:0] {
        CNT_IDLE = 2'd0,
        CNT_RUN  = 2'd1,
        CNT_WRAP = 2'd2
    } cntState_e;

endpackage

// File: rtl/bus_timer.sv
// Memory-mapped reload timer with level irq; optional free-running SYSTICK when BUS_TIMER_SYSTICK_EN is defined.
// Latency: reads are combinational (zero cycles); writes land on the strobe edge and are visible the next cycle.
// Backpressure: none -- every bus access completes in the cycle it is presented.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    output logic [31:0] Device_Read_Data,
    output logic        irq
);

    logic [31:0] thReg;
    logic [31:0] tlReg;
    logic [3:0]  tconReg;
    logic        winHit;
    logic [4:0]  offset;
    logic        wrTh;
    logic        wrTl;
    logic        wrTcon;
    cntState_e   cntState;

    assign winHit = (MemBus_Address[31:5] == BASE_ADDR[31:5]);
    assign offset = MemBus_Address[4:0];
    assign wrTh   = MemWrite && winHit && (offset == OFF_TH);
    assign wrTl   = MemWrite && winHit && (offset == OFF_TL);
    assign wrTcon = MemWrite && winHit && (offset == OFF_TCON);

    assign cntState = !tconReg[TCON_EN]      ? CNT_IDLE :
                      (tlReg == 32'hFFFF_FFFF) ? CNT_WRAP : CNT_RUN;

    always_ff @(posedge clk) begin
        if (!reset) begin
            thReg   <= '0;
            tlReg   <= '0;
            tconReg <= '0;
        end else begin
            if (wrTh) begin
                thReg <= MemBus_Write_Data;
            end

            // A software TL write overrides both counting and the reload.
            if (wrTl) begin
                tlReg <= MemBus_Write_Data;
            end else if (cntState == CNT_WRAP) begin
                tlReg <= thReg;
            end else if (cntState == CNT_RUN) begin
                tlReg <= tlReg + 32'd1;
            end

            // A wrap that lost to a TL write has no side effects on TCON.
            if (wrTcon) begin
                tconReg <= MemBus_Write_Data[3:0];
            end else if ((cntState == CNT_WRAP) && !wrTl) begin
                if (tconReg[TCON_IE]) begin
                    tconReg[TCON_IF] <= 1'b1;
                end
                if (tconReg[TCON_ONESHOT]) begin
                    tconReg[TCON_EN] <= 1'b0;
                end
            end
        end
    end

`ifdef BUS_TIMER_SYSTICK_EN
    logic [31:0] sysTick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sysTick <= '0;
        end else begin
            sysTick <= sysTick + 32'd1;
        end
    end
`endif

    always_comb begin
        Device_Read_Data = '0;
        if (MemRead && winHit) begin
            case (offset)
                OFF_TH:      Device_Read_Data = thReg;
                OFF_TL:      Device_Read_Data = tlReg;
                OFF_TCON:    Device_Read_Data = {28'h0, tconReg};
`ifdef BUS_TIMER_SYSTICK_EN
                OFF_SYSTICK: Device_Read_Data = sysTick;
`endif
                default:     Device_Read_Data = '0;
            endcase
        end
    end

    assign irq = tconReg[TCON_IF] & tconReg[TCON_IE];

endmodule
